// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer for the IF stage: owns pc, drives the 4:1 next-PC mux select, parks redirects across stalls.
// Optional feature macro: PC_ALIGN_CHECK_EN (reject misaligned targets and raise a sticky align_err).
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        j_en,
    input  logic        jr_en,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] npc,
    output logic [1:0]  pc_op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic        pend,
    output logic        align_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  pend_op;
    logic [31:0] pend_tgt;

    logic [1:0]  req_op;
    logic [31:0] req_tgt;
    logic        req_ok;
    logic [31:0] req_load;
    logic [31:0] npc_load;
    logic        rel_ok;

    // Handshake: a redirect request is consumed in the cycle it is seen in RUN;
    // stall=1 means the fetch is not accepted, so pc holds and any winner is parked.
    always_comb begin
        req_op  = 2'b00;
        req_tgt = 32'h0;
        if (jr_en) begin
            req_op  = 2'b11;
            req_tgt = jr_target;
        end else if (j_en) begin
            req_op  = 2'b10;
            req_tgt = j_target;
        end else if (br_taken) begin
            req_op  = 2'b01;
            req_tgt = br_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic align_set;
    assign req_ok   = (req_op != 2'b00) && (req_tgt[1:0] == 2'b00);
    assign req_load = req_tgt;
    assign npc_load = npc;
    assign rel_ok   = (pend_tgt[1:0] == 2'b00);
    assign align_set = ((state == RUN) && (req_op != 2'b00) && (req_tgt[1:0] != 2'b00)) ||
                       ((state == PEND) && !stall && !rel_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            align_err <= 1'b0;
        else if (align_set)
            align_err <= 1'b1;
    end
`else
    // Misaligned targets are accepted with the low two bits dropped.
    assign req_ok    = (req_op != 2'b00);
    assign req_load  = req_tgt & 32'hFFFF_FFFC;
    assign npc_load  = npc & 32'hFFFF_FFFC;
    assign rel_ok    = 1'b1;
    assign align_err = 1'b0;
`endif

    always_comb begin
        pc_op = 2'b00;
        case (state)
            RUN:     pc_op = req_ok ? req_op : 2'b00;
            PEND:    pc_op = pend_op;
            default: pc_op = 2'b00;
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            pend     <= 1'b0;
            pend_op  <= 2'b00;
            pend_tgt <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        pc <= npc_load;
                    end else if (req_ok) begin
                        pend_op  <= req_op;
                        pend_tgt <= req_load;
                        pend     <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    // The parked redirect is older than anything arriving now, so new requests are ignored.
                    if (!stall) begin
                        pc       <= rel_ok ? pend_tgt : pc_plus4;
                        pend     <= 1'b0;
                        pend_op  <= 2'b00;
                        pend_tgt <= 32'h0;
                        state    <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: boot, sequencing, priority, parking across stalls, async reset, alignment, wrap.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic        j_en = 1'b0;
    logic        jr_en = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] j_target = 32'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] npc;
    logic [1:0]  pc_op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        pend;
    logic        align_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Environment model of the 4:1 next-PC mux.
    always_comb begin
        case (pc_op)
            2'b01:   npc = br_target;
            2'b10:   npc = j_target;
            2'b11:   npc = jr_target;
            default: npc = pc_plus4;
        endcase
    end

    pc_seq_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .j_en(j_en), .jr_en(jr_en),
        .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
        .npc(npc), .pc_op(pc_op), .pc(pc), .pc_plus4(pc_plus4),
        .pc_valid(pc_valid), .pend(pend), .align_err(align_err), .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        br_taken = 1'b0;
        j_en     = 1'b0;
        jr_en    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align got %b exp 0", align_err); end
        checks++; if (pc_op !== 2'b00) begin errors++; $display("FAIL reset_op got %b exp 00", pc_op); end
        reset = 1'b0;
        // Request during BOOT must be ignored.
        br_taken = 1'b1; br_target = 32'h3100;
        #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL boot_state got %0d exp 0", dbg_state); end
        checks++; if (pc_op !== 2'b00) begin errors++; $display("FAIL boot_op got %b exp 00", pc_op); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", pc_valid); end
        step(); clear_req();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL run0_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL run0_valid got %b exp 1", pc_valid); end
    endtask

    task automatic test_sequential();
        step();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL seq1_pc got %h exp %h", pc, 32'h3004); end
        checks++; if (pc_op !== 2'b00) begin errors++; $display("FAIL seq1_op got %b exp 00", pc_op); end
        step();
        checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL seq2_pc got %h exp %h", pc, 32'h3008); end
        checks++; if (pc_plus4 !== 32'h300C) begin errors++; $display("FAIL seq2_plus4 got %h exp %h", pc_plus4, 32'h300C); end
        repeat (2) step();
        checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL seq4_pc got %h exp %h", pc, 32'h3010); end
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_target = 32'h3100;
        #1;
        checks++; if (pc_op !== 2'b01) begin errors++; $display("FAIL br_op got %b exp 01", pc_op); end
        step(); clear_req();
        checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL br_pc got %h exp %h", pc, 32'h3100); end
    endtask

    task automatic test_priority();
        jr_en = 1'b1; jr_target = 32'h4000;
        j_en = 1'b1; j_target = 32'h5000;
        br_taken = 1'b1; br_target = 32'h6000;
        #1;
        checks++; if (pc_op !== 2'b11) begin errors++; $display("FAIL prio_op got %b exp 11", pc_op); end
        step(); clear_req();
        checks++; if (pc !== 32'h4000) begin errors++; $display("FAIL prio_pc got %h exp %h", pc, 32'h4000); end
        j_en = 1'b1; j_target = 32'h4800;
        br_taken = 1'b1; br_target = 32'h6000;
        #1;
        checks++; if (pc_op !== 2'b10) begin errors++; $display("FAIL prio2_op got %b exp 10", pc_op); end
        clear_req();
    endtask

    task automatic test_pend();
        stall = 1'b1;
        step();
        checks++; if (pc !== 32'h4000) begin errors++; $display("FAIL stall_hold_pc got %h exp %h", pc, 32'h4000); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL stall_nopend got %b exp 0", pend); end
        j_en = 1'b1; j_target = 32'h3400;
        #1;
        checks++; if (pc_op !== 2'b10) begin errors++; $display("FAIL park_op got %b exp 10", pc_op); end
        step(); clear_req();
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL park_pend got %b exp 1", pend); end
        checks++; if (pc !== 32'h4000) begin errors++; $display("FAIL park_pc got %h exp %h", pc, 32'h4000); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL park_state got %0d exp 2", dbg_state); end
        step();
        br_taken = 1'b1; br_target = 32'h3800;
        #1;
        checks++; if (pc_op !== 2'b10) begin errors++; $display("FAIL pend_op got %b exp 10", pc_op); end
        step(); clear_req();
        checks++; if (pc !== 32'h4000) begin errors++; $display("FAIL pend_hold_pc got %h exp %h", pc, 32'h4000); end
        stall = 1'b0;
        #1;
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL release_pend got %b exp 1", pend); end
        step();
        checks++; if (pc !== 32'h3400) begin errors++; $display("FAIL release_pc got %h exp %h", pc, 32'h3400); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL after_release_pend got %b exp 0", pend); end
        step();
        checks++; if (pc !== 32'h3404) begin errors++; $display("FAIL lost_branch_pc got %h exp %h", pc, 32'h3404); end
    endtask

    task automatic test_reset_in_pend();
        stall = 1'b1;
        jr_en = 1'b1; jr_target = 32'h5000;
        step(); clear_req();
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rp_pend got %b exp 1", pend); end
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rp_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rp_pend_clr got %b exp 0", pend); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rp_state got %0d exp 0", dbg_state); end
        stall = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rp_boot_valid got %b exp 0", pc_valid); end
        step();
        checks++; if (pc !== 32'h3000 || pc_valid !== 1'b1) begin errors++; $display("FAIL rp_run_pc got %h/%b exp 3000/1", pc, pc_valid); end
        step();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL rp_seq_pc got %h exp %h", pc, 32'h3004); end
    endtask

    task automatic test_align();
        jr_en = 1'b1; jr_target = 32'h3002;
        #1;
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (pc_op !== 2'b00) begin errors++; $display("FAIL align_op got %b exp 00", pc_op); end
        step(); clear_req();
        checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL align_pc got %h exp %h", pc, 32'h3008); end
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_err got %b exp 1", align_err); end
        step();
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky got %b exp 1", align_err); end
`else
        checks++; if (pc_op !== 2'b11) begin errors++; $display("FAIL align_op got %b exp 11", pc_op); end
        step(); clear_req();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL align_pc got %h exp %h", pc, 32'h3000); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_err got %b exp 0", align_err); end
`endif
    endtask

    task automatic test_wrap();
        j_en = 1'b1; j_target = 32'hFFFF_FFFC;
        step(); clear_req();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'hFFFF_FFFC); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_pend();
        test_reset_in_pend();
        test_align();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
